// File: rtl/occ_search_ctrl_if.sv
// Request/result and Occ ROM signals of the FM-index backward-search sequencer.
// Master drives requests and ROM data; slave is the sequencer.
interface occ_search_ctrl_if #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
);
    logic                   start;
    logic [2*MAX_LEN-1:0]   query;
    logic [LEN_W-1:0]       query_len;
    logic [31:0]            c_table;
    logic                   occ_ce;
    logic [7:0]             occ_addr_1;
    logic [7:0]             occ_addr_2;
    logic [31:0]            occ_data_1;
    logic [31:0]            occ_data_2;
    logic                   busy;
    logic                   done;
    logic                   found;
    logic [7:0]             sa_k;
    logic [7:0]             sa_l;

    modport master (
        output start, query, query_len, c_table,
        output occ_data_1, occ_data_2,
        input  occ_ce, occ_addr_1, occ_addr_2,
        input  busy, done, found, sa_k, sa_l
    );

    modport slave (
        input  start, query, query_len, c_table,
        input  occ_data_1, occ_data_2,
        output occ_ce, occ_addr_1, occ_addr_2,
        output busy, done, found, sa_k, sa_l
    );
endinterface

// File: rtl/occ_search_ctrl.sv
// FM-index backward search: walks the query last-to-first, narrowing [k,l]
// using two Occ ROM lookups per base.
module occ_search_ctrl #(
    parameter int REF_LEN = 256,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    occ_search_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STEP,
        DONE
    } state_t;

    localparam logic [7:0] L_INIT = 8'(REF_LEN - 1);

    state_t               state;
    logic [2*MAX_LEN-1:0] query_q;
    logic [LEN_W-1:0]     len_q;
    logic [31:0]          ctab_q;
    logic [7:0]           k;
    logic [7:0]           l;
    logic [LEN_W-1:0]     idx;
    logic                 busy_q;
    logic                 done_q;
    logic                 found_q;
    logic [7:0]           sa_k_q;
    logic [7:0]           sa_l_q;

    logic [1:0]           a;
    logic [7:0]           c_a;
    logic [7:0]           ok;
    logic [7:0]           ol;
    logic [8:0]           kn;
    logic [8:0]           sl;
    logic                 hit;
    logic [7:0]           l_next;

    function automatic logic [7:0] pick(
        input logic [31:0] w,
        input logic [1:0]  s
    );
        logic [7:0] r;
        unique case (s)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            default: r = w[31:24];
        endcase
        return r;
    endfunction

    assign a   = 2'(query_q >> {idx, 1'b0});
    assign c_a = pick(ctab_q, a);
    // Occ(a,-1) is defined as zero, so port 1 is ignored while k is 0
    assign ok  = (k == 8'd0) ? 8'd0 : pick(bus.occ_data_1, a);
    assign ol  = pick(bus.occ_data_2, a);
    assign kn  = {1'b0, c_a} + {1'b0, ok};
    assign sl  = {1'b0, c_a} + {1'b0, ol};
    assign hit = kn < sl;
    assign l_next = 8'(sl - 9'd1);

    always_comb begin
        bus.occ_ce     = 1'b0;
        bus.occ_addr_1 = 8'd0;
        bus.occ_addr_2 = 8'd0;
        if (state == STEP) begin
            bus.occ_ce     = 1'b1;
            bus.occ_addr_1 = (k == 8'd0) ? 8'd0 : k - 8'd1;
            bus.occ_addr_2 = l;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.found = found_q;
    assign bus.sa_k  = sa_k_q;
    assign bus.sa_l  = sa_l_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            query_q <= '0;
            len_q   <= '0;
            ctab_q  <= '0;
            k       <= '0;
            l       <= '0;
            idx     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            sa_k_q  <= '0;
            sa_l_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        query_q <= bus.query;
                        len_q   <= bus.query_len;
                        ctab_q  <= bus.c_table;
                        busy_q  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    k   <= 8'd0;
                    l   <= L_INIT;
                    idx <= len_q - 1'b1;
                    if (len_q == '0) begin
                        found_q <= 1'b1;
                        sa_k_q  <= 8'd0;
                        sa_l_q  <= L_INIT;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (hit) begin
                        k <= kn[7:0];
                        l <= l_next;
                        if (idx == '0) begin
                            found_q <= 1'b1;
                            sa_k_q  <= kn[7:0];
                            sa_l_q  <= l_next;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end else begin
                        // empty interval: report the last non-empty one
                        found_q <= 1'b0;
                        sa_k_q  <= k;
                        sa_l_q  <= l;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_occ_search_ctrl.sv
// Bench for occ_search_ctrl on reference "AC$" (BWT C,$,A) with a
// count-based backward-search model and a behavioural Occ ROM.
module tb_occ_search_ctrl;

    localparam int REF_LEN = 3;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam logic [31:0] CTAB = 32'h0000_0201;
    // BWT symbols: 0..3 = A,C,G,T ; 4 = '$'
    localparam int BWT [3] = '{1, 4, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;

    occ_search_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

    occ_search_ctrl #(
        .REF_LEN(REF_LEN),
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic int occ(input int sym, input int r);
        int c;
        c = 0;
        for (int i = 0; i < REF_LEN; i++)
            if (i <= r && BWT[i] == sym) c++;
        return c;
    endfunction

    function automatic logic [31:0] rom_row(input logic [7:0] r);
        logic [31:0] w;
        w = '0;
        if (int'(r) < REF_LEN)
            for (int s = 0; s < 4; s++)
                w[8*s +: 8] = 8'(occ(s, int'(r)));
        return w;
    endfunction

    always_comb begin
        bus.occ_data_1 = 32'h0;
        bus.occ_data_2 = 32'h0;
        if (bus.occ_ce) begin
            bus.occ_data_1 = rom_row(bus.occ_addr_1);
            bus.occ_data_2 = rom_row(bus.occ_addr_2);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    int exp_a1 [$];
    int exp_a2 [$];
    int exp_steps;
    int exp_found;
    int exp_k;
    int exp_l;
    int hold_found = 0;
    int hold_k = 0;
    int hold_l = 0;
    bit active = 0;
    int cyc = 0;
    int done_cyc = 0;

    task automatic run_model(input logic [63:0] q, input int len);
        int k, l, sym, c, nk, nl;
        k = 0;
        l = REF_LEN - 1;
        exp_found = 1;
        exp_steps = 0;
        exp_a1.delete();
        exp_a2.delete();
        for (int i = len - 1; i >= 0; i--) begin
            sym = int'((q >> (2 * i)) & 64'd3);
            c = int'((CTAB >> (8 * sym)) & 32'hff);
            exp_a1.push_back(k == 0 ? 0 : k - 1);
            exp_a2.push_back(l);
            exp_steps++;
            nk = c + (k > 0 ? occ(sym, k - 1) : 0);
            nl = c + occ(sym, l) - 1;
            if (nk > nl) begin
                exp_found = 0;
                break;
            end
            k = nk;
            l = nl;
        end
        exp_k = k;
        exp_l = l;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (active) begin
                cyc++;
                chk("busy", int'(bus.busy), 1);
                if (cyc == 1) begin
                    chk("setup_ce", int'(bus.occ_ce), 0);
                    chk("setup_done", int'(bus.done), 0);
                end else if (cyc <= 1 + exp_steps) begin
                    chk("step_ce", int'(bus.occ_ce), 1);
                    chk("step_addr1", int'(bus.occ_addr_1), exp_a1[cyc-2]);
                    chk("step_addr2", int'(bus.occ_addr_2), exp_a2[cyc-2]);
                    chk("step_done", int'(bus.done), 0);
                end else begin
                    chk("done", int'(bus.done), 1);
                    chk("done_ce", int'(bus.occ_ce), 0);
                    chk("found", int'(bus.found), exp_found);
                    chk("sa_k", int'(bus.sa_k), exp_k);
                    chk("sa_l", int'(bus.sa_l), exp_l);
                    hold_found = exp_found;
                    hold_k = exp_k;
                    hold_l = exp_l;
                    done_cyc = cyc;
                    active = 0;
                end
            end else begin
                chk("idle_busy", int'(bus.busy), 0);
                chk("idle_done", int'(bus.done), 0);
                chk("idle_ce", int'(bus.occ_ce), 0);
                chk("idle_addr1", int'(bus.occ_addr_1), 0);
                chk("idle_addr2", int'(bus.occ_addr_2), 0);
                chk("hold_found", int'(bus.found), hold_found);
                chk("hold_k", int'(bus.sa_k), hold_k);
                chk("hold_l", int'(bus.sa_l), hold_l);
            end
        end
    end

    task automatic launch(input logic [63:0] q, input int len, input bit scramble);
        run_model(q, len);
        @(posedge clk) #2;
        bus.query = q;
        bus.query_len = LEN_W'(len);
        bus.c_table = CTAB;
        bus.start = 1'b1;
        @(posedge clk) #2;
        bus.start = 1'b0;
        cyc = 0;
        done_cyc = 0;
        active = 1;
        if (scramble) begin
            bus.query = 64'hFFFF_FFFF_FFFF_FFFF;
            bus.query_len = 6'd5;
            bus.c_table = 32'h0303_0303;
        end
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40 && active; i++) @(posedge clk);
        if (active) begin
            chk({nm, "_timeout"}, 1, 0);
            active = 0;
        end
        @(posedge clk) #2;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.query = '0;
        bus.query_len = '0;
        bus.c_table = '0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_found", int'(bus.found), 0);
        chk("rst_sa_l", int'(bus.sa_l), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        // "C"
        launch(64'b01, 1, 1'b0);
        wait_done("c");
        chk("c_lat", done_cyc, 3);
        chk("c_found", int'(bus.found), 1);
        chk("c_k", int'(bus.sa_k), 2);
        chk("c_l", int'(bus.sa_l), 2);

        // "AC", inputs scrambled after start
        launch(64'b0100, 2, 1'b1);
        wait_done("ac");
        chk("ac_lat", done_cyc, 4);
        chk("ac_k", int'(bus.sa_k), 1);
        chk("ac_l", int'(bus.sa_l), 1);

        // "CA" terminates at step 2
        launch(64'b0001, 2, 1'b0);
        wait_done("ca");
        chk("ca_lat", done_cyc, 4);
        chk("ca_found", int'(bus.found), 0);
        chk("ca_k", int'(bus.sa_k), 1);
        chk("ca_l", int'(bus.sa_l), 1);

        // empty query
        launch(64'b0, 0, 1'b0);
        wait_done("len0");
        chk("len0_lat", done_cyc, 2);
        chk("len0_found", int'(bus.found), 1);
        chk("len0_l", int'(bus.sa_l), 2);

        // second start during STEP is ignored
        launch(64'b0100, 2, 1'b0);
        @(posedge clk) #2;
        bus.start = 1'b1;
        @(posedge clk) #2;
        bus.start = 1'b0;
        wait_done("busy_start");
        chk("bs_k", int'(bus.sa_k), 1);
        repeat (3) @(posedge clk);

        // reset during step 1 of "AC"
        launch(64'b0100, 2, 1'b0);
        @(posedge clk) #2;
        rst = 1'b1;
        active = 0;
        hold_found = 0;
        hold_k = 0;
        hold_l = 0;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_ce", int'(bus.occ_ce), 0);
        chk("arst_found", int'(bus.found), 0);
        chk("arst_k", int'(bus.sa_k), 0);
        chk("arst_l", int'(bus.sa_l), 0);
        @(posedge clk) #2;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        launch(64'b0100, 2, 1'b0);
        wait_done("after_rst");
        chk("ar_found", int'(bus.found), 1);
        chk("ar_k", int'(bus.sa_k), 1);
        chk("ar_l", int'(bus.sa_l), 1);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
